button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 1000000, cycles a synchronized level must hold before acceptance (10 ms at 100 MHz).
REQ-002 SHALL have parameter STABLE_W, default 20, width of the stability counter; STABLE_CYCLES < 2**STABLE_W.
REQ-003 SHALL have parameter LONG_CYCLES, default 100000000, accepted-press hold time for a long-press event (1 s).
REQ-004 SHALL have parameter LONG_W, default 27, width of the hold counter; LONG_CYCLES < 2**LONG_W.
REQ-005 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-007 SHALL have port btn_raw, input, 1, asynchronous bouncing push-button pin.
REQ-008 SHALL have port cnt_clr, input, 1, synchronous clear of press_count.
REQ-009 SHALL have port level, output, 1, debounced button level.
REQ-010 SHALL have port press_pulse, output, 1, one-cycle strobe on each accepted press.
REQ-011 SHALL have port release_pulse, output, 1, one-cycle strobe on each accepted release.
REQ-012 SHALL have port long_pulse, output, 1, one-cycle strobe when a press reaches LONG_CYCLES.
REQ-013 SHALL have port press_count, output, 16, count of accepted presses.

Function
REQ-014 SHALL pass btn_raw through a two-flop synchronizer; only the second flop (sync) feeds the FSM.
REQ-015 SHALL implement FSM states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-016 IDLE: sync=1 -> PRESS_WAIT, stability counter loaded to 1.
REQ-017 PRESS_WAIT: sync=0 -> IDLE (bounce rejected, no output change); counter reaching STABLE_CYCLES -> PRESSED.
REQ-018 PRESSED: sync=0 -> RELEASE_WAIT, counter loaded to 1.
REQ-019 RELEASE_WAIT: sync=1 -> PRESSED (no output change); counter reaching STABLE_CYCLES -> IDLE.
REQ-020 On PRESS_WAIT->PRESSED, level SHALL become 1 and press_pulse SHALL be 1 for exactly that one cycle.
REQ-021 On RELEASE_WAIT->IDLE, level SHALL become 0 and release_pulse SHALL be 1 for exactly that one cycle.
REQ-022 Latency from a clean btn_raw edge to the level change SHALL be 2 + STABLE_CYCLES cycles.
REQ-023 press_count SHALL increment by 1 with each press_pulse and wrap from 0xFFFF to 0x0000.
REQ-024 If cnt_clr and press_pulse coincide, press_count SHALL become 1; cnt_clr alone sets it to 0.
REQ-025 press/release/long pulses SHALL never assert in the same cycle.

Reset
REQ-026 Reset SHALL force state IDLE, synchronizer flops 0, all counters 0.
REQ-027 Reset SHALL force level=0, press_pulse=0, release_pulse=0, long_pulse=0, press_count=0.
REQ-028 Reset asserted mid-press SHALL emit no release_pulse; after deassertion a still-held button SHALL be re-accepted as a new press.

Configuration
REQ-029 With BUTTON_LONG_PRESS_EN defined, the hold counter SHALL count in PRESSED and RELEASE_WAIT, clear on entry to PRESSED from PRESS_WAIT, and assert long_pulse once when it reaches LONG_CYCLES; it SHALL stop until the next accepted press.
REQ-030 Without BUTTON_LONG_PRESS_EN, the hold counter SHALL be absent and long_pulse SHALL be tied to 0.

Structure
REQ-031 The FSM state enum and default timing constants SHALL reside in shared package button_pkg.
REQ-032 The synchronizer SHALL be sub-module sync_2ff, reused by other asynchronous-input blocks.

Verification (STABLE_CYCLES=8, LONG_CYCLES=40)
REQ-033 Clean press held 20 cycles -> level rises 10 cycles after btn_raw edge; one press_pulse; press_count=1.
REQ-034 Bounce 1/0 every 3 cycles for 30 cycles, then stable 1 -> exactly one press_pulse, 10 cycles after the last edge.
REQ-035 Release with 5-cycle glitch back to 1 -> no release_pulse until 10 cycles after final fall; level then 0.
REQ-036 press_count preset to 0xFFFF by 65535 presses, one more press -> press_count=0x0000; cnt_clr coincident with press -> 1.
REQ-037 Hold 60 cycles with BUTTON_LONG_PRESS_EN -> single long_pulse 40 cycles after press_pulse; without the macro -> long_pulse stays 0.
REQ-038 Reset pulse while PRESSED, button still held -> outputs 0 immediately, no release_pulse, press_pulse 10 cycles after deassertion.

Source files
------------

// File: rtl/button_pkg.sv
// Shared FSM state type and default timing constants for push-button conditioning.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } button_state_t;

    // Defaults assume a 100 MHz clock: 10 ms debounce, 1 s long press.
    localparam int DEF_STABLE_CYCLES = 1000000;
    localparam int DEF_STABLE_W      = 20;
    localparam int DEF_LONG_CYCLES   = 100000000;
    localparam int DEF_LONG_W        = 27;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; q is the second flop.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // capture the asynchronous input through two flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/button_conditioner.sv
// Debounces a bouncing push-button into a level, press/release strobes and a press counter.
// Optional long-press strobe is built when BUTTON_LONG_PRESS_EN is defined.
module button_conditioner
    import button_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int STABLE_W      = DEF_STABLE_W,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int LONG_W        = DEF_LONG_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_raw,
    input  logic        cnt_clr,
    output logic        level,
    output logic        press_pulse,
    output logic        release_pulse,
    output logic        long_pulse,
    output logic [15:0] press_count
);

    if (STABLE_CYCLES < 32'sd1 || (STABLE_CYCLES >> STABLE_W) != 32'sd0) begin : g_bad_stable
        $error("STABLE_CYCLES must be in 1 .. 2**STABLE_W-1");
    end
    if (LONG_CYCLES < 32'sd1 || (LONG_CYCLES >> LONG_W) != 32'sd0) begin : g_bad_long
        $error("LONG_CYCLES must be in 1 .. 2**LONG_W-1");
    end

    // The count is compared one step early so acceptance lands exactly STABLE_CYCLES
    // edges after the first edge that saw the new synchronized level.
    localparam logic [STABLE_W-1:0] STABLE_ONE  = STABLE_W'(1);
    localparam logic [STABLE_W-1:0] STABLE_ZERO = STABLE_W'(0);
    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_CYCLES - 1);

    logic          sync_s;
    button_state_t state_r, state_s;
    logic [STABLE_W-1:0] stable_cnt_r, stable_cnt_s;
    logic          press_evt_s, release_evt_s;
    logic          level_r, level_s;
    logic          press_pulse_r, release_pulse_r;
    logic [15:0]   press_count_r, press_count_s;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_raw),
        .q     (sync_s)
    );

    // next-state, stability counter and accepted-edge events
    always_comb begin
        state_s       = state_r;
        stable_cnt_s  = stable_cnt_r;
        press_evt_s   = 1'b0;
        release_evt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (sync_s) begin
                    state_s      = PRESS_WAIT;
                    stable_cnt_s = STABLE_ONE;
                end else begin
                    stable_cnt_s = STABLE_ZERO;
                end
            end
            PRESS_WAIT: begin
                if (!sync_s) begin
                    state_s      = IDLE;
                    stable_cnt_s = STABLE_ZERO;
                end else if (stable_cnt_r >= STABLE_LAST) begin
                    state_s      = PRESSED;
                    stable_cnt_s = STABLE_ZERO;
                    press_evt_s  = 1'b1;
                end else begin
                    stable_cnt_s = stable_cnt_r + STABLE_ONE;
                end
            end
            PRESSED: begin
                if (!sync_s) begin
                    state_s      = RELEASE_WAIT;
                    stable_cnt_s = STABLE_ONE;
                end else begin
                    stable_cnt_s = STABLE_ZERO;
                end
            end
            RELEASE_WAIT: begin
                if (sync_s) begin
                    state_s      = PRESSED;
                    stable_cnt_s = STABLE_ZERO;
                end else if (stable_cnt_r >= STABLE_LAST) begin
                    state_s       = IDLE;
                    stable_cnt_s  = STABLE_ZERO;
                    release_evt_s = 1'b1;
                end else begin
                    stable_cnt_s = stable_cnt_r + STABLE_ONE;
                end
            end
            default: begin
                state_s      = IDLE;
                stable_cnt_s = STABLE_ZERO;
            end
        endcase
    end

    // debounced level and press counter; a clear coinciding with a press leaves one press
    always_comb begin
        level_s       = level_r;
        press_count_s = press_count_r;
        if (press_evt_s) begin
            level_s = 1'b1;
        end else if (release_evt_s) begin
            level_s = 1'b0;
        end else begin
            level_s = level_r;
        end
        if (press_evt_s) begin
            press_count_s = cnt_clr ? 16'd1 : press_count_r + 16'd1;
        end else if (cnt_clr) begin
            press_count_s = 16'd0;
        end else begin
            press_count_s = press_count_r;
        end
    end

    // FSM state and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= IDLE;
            stable_cnt_r    <= STABLE_ZERO;
            level_r         <= 1'b0;
            press_pulse_r   <= 1'b0;
            release_pulse_r <= 1'b0;
            press_count_r   <= 16'd0;
        end else begin
            state_r         <= state_s;
            stable_cnt_r    <= stable_cnt_s;
            level_r         <= level_s;
            press_pulse_r   <= press_evt_s;
            release_pulse_r <= release_evt_s;
            press_count_r   <= press_count_s;
        end
    end

    assign level         = level_r;
    assign press_pulse   = press_pulse_r;
    assign release_pulse = release_pulse_r;
    assign press_count   = press_count_r;

`ifdef BUTTON_LONG_PRESS_EN
    localparam logic [LONG_W-1:0] LONG_ONE  = LONG_W'(1);
    localparam logic [LONG_W-1:0] LONG_FULL = LONG_W'(LONG_CYCLES);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

    logic [LONG_W-1:0] hold_r, hold_s;
    logic              long_evt_s;
    logic              long_pulse_r;

    // Hold time counts while the button is accepted as down; it saturates at LONG_CYCLES
    // so the strobe fires once, and it skips the release edge to keep strobes exclusive.
    always_comb begin
        hold_s     = hold_r;
        long_evt_s = 1'b0;
        if (press_evt_s) begin
            hold_s = LONG_W'(0);
        end else if ((state_r == PRESSED || state_r == RELEASE_WAIT) &&
                     !release_evt_s && (hold_r < LONG_FULL)) begin
            hold_s     = hold_r + LONG_ONE;
            long_evt_s = (hold_r == LONG_LAST);
        end else begin
            hold_s = hold_r;
        end
    end

    // hold counter and long-press strobe register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_r       <= LONG_W'(0);
            long_pulse_r <= 1'b0;
        end else begin
            hold_r       <= hold_s;
            long_pulse_r <= long_evt_s;
        end
    end

    assign long_pulse = long_pulse_r;
`else
    assign long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus random bounce,
// every cycle compared against a run-length debounce model.
module tb_button_conditioner;

    localparam int STABLE = 8;
    localparam int LONG   = 40;
`ifdef BUTTON_LONG_PRESS_EN
    localparam logic LONG_EN = 1'b1;
`else
    localparam logic LONG_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_raw;
    logic        cnt_clr;
    logic        level;
    logic        press_pulse;
    logic        release_pulse;
    logic        long_pulse;
    logic [15:0] press_count;

    int total = 0;
    int bad   = 0;

    // reference model: input delay line, run length of the disagreeing level, hold time
    logic        m_d1, m_d2, m_level, m_armed;
    int          m_run, m_hold;
    logic [15:0] m_count;
    logic        e_press, e_rel, e_long;
    int          n_press, n_rel, n_long;

    button_conditioner #(
        .STABLE_CYCLES (STABLE),
        .STABLE_W      (4),
        .LONG_CYCLES   (LONG),
        .LONG_W        (6)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_raw       (btn_raw),
        .cnt_clr       (cnt_clr),
        .level         (level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .press_count   (press_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_d1 = 1'b0; m_d2 = 1'b0; m_level = 1'b0; m_armed = 1'b0;
        m_run = 0; m_hold = 0; m_count = 16'd0;
        e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
    endtask

    // Level flips once the synchronized input (raw delayed two edges) has disagreed
    // with it for STABLE consecutive edges.
    task automatic model_edge(input logic b, input logic clr);
        logic s, was;
        e_press = 1'b0; e_rel = 1'b0; e_long = 1'b0;
        if (reset) begin
            model_clear();
        end else begin
            s = m_d2; m_d2 = m_d1; m_d1 = b;
            was = m_level;
            if (s == m_level) begin
                m_run = 0;
            end else begin
                m_run++;
                if (m_run == STABLE) begin
                    m_run = 0;
                    m_level = s;
                    if (s) e_press = 1'b1;
                    else   e_rel = 1'b1;
                end
            end
            if (e_press) begin
                m_hold = 0; m_armed = 1'b1;
            end else if (was && !e_rel && m_armed) begin
                m_hold++;
                if (m_hold == LONG) begin
                    m_armed = 1'b0;
                    e_long = LONG_EN;
                end
            end
            if (e_press) m_count = clr ? 16'd1 : m_count + 16'd1;
            else if (clr) m_count = 16'd0;
        end
    endtask

    task automatic check_all();
        check("level",   {15'd0, level},         {15'd0, m_level});
        check("press",   {15'd0, press_pulse},   {15'd0, e_press});
        check("release", {15'd0, release_pulse}, {15'd0, e_rel});
        check("long",    {15'd0, long_pulse},    {15'd0, e_long});
        check("count",   press_count,            m_count);
    endtask

    task automatic tick(input logic b, input logic clr);
        btn_raw = b;
        cnt_clr = clr;
        @(posedge clk);
        model_edge(b, clr);
        #1;
        n_press += int'(press_pulse);
        n_rel   += int'(release_pulse);
        n_long  += int'(long_pulse);
        check_all();
    endtask

    initial begin
        reset = 1'b1; btn_raw = 1'b0; cnt_clr = 1'b0;
        model_clear();
        n_press = 0; n_rel = 0; n_long = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;

        // clean press held 20 cycles, then clean release
        for (int i = 1; i <= 20; i++) begin
            tick(1'b1, 1'b0);
            if (i == 9)  check("clean_lat_pre", {15'd0, level}, 16'd0);
            if (i == 10) check("clean_lat", {15'd0, level & press_pulse}, 16'd1);
        end
        check("clean_count", press_count, 16'd1);
        repeat (20) tick(1'b0, 1'b0);

        // bounce every 3 cycles for 30 cycles, then stable high
        n_press = 0;
        for (int i = 0; i < 30; i++) tick(((i / 3) % 2) == 0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            tick(1'b1, 1'b0);
            if (i == 10) check("bounce_lat", {15'd0, press_pulse}, 16'd1);
        end
        check("bounce_one_press", 16'(n_press), 16'd1);

        // release with a 5-cycle glitch back to 1
        n_rel = 0;
        repeat (5) tick(1'b0, 1'b0);
        repeat (5) tick(1'b1, 1'b0);
        check("glitch_no_release", 16'(n_rel), 16'd0);
        for (int i = 1; i <= 20; i++) begin
            tick(1'b0, 1'b0);
            if (i == 9)  check("release_pre", {15'd0, level}, 16'd1);
            if (i == 10) check("release_lat", {15'd0, release_pulse}, 16'd1);
        end
        check("release_level", {15'd0, level}, 16'd0);

        // long hold of 60 cycles
        n_long = 0;
        for (int i = 1; i <= 60; i++) begin
            tick(1'b1, 1'b0);
            if (i == 50) check("long_lat", {15'd0, long_pulse}, {15'd0, LONG_EN});
        end
        check("long_once", 16'(n_long), {15'd0, LONG_EN});
        repeat (20) tick(1'b0, 1'b0);

        // reset pulse while pressed and still held
        repeat (12) tick(1'b1, 1'b0);
        check("pre_reset_level", {15'd0, level}, 16'd1);
        n_rel = 0;
        reset = 1'b1;
        #1;
        model_clear();
        check_all();
        repeat (2) tick(1'b1, 1'b0);
        reset = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick(1'b1, 1'b0);
            if (i == 10) check("reset_repress", {15'd0, press_pulse}, 16'd1);
        end
        check("reset_no_release", 16'(n_rel), 16'd0);
        repeat (20) tick(1'b0, 1'b0);

        // counter wrap from 0xFFFF and clear interplay
        force dut.press_count_r = 16'hFFFF;
        #1;
        release dut.press_count_r;
        m_count = 16'hFFFF;
        check("preset", press_count, m_count);
        repeat (12) tick(1'b1, 1'b0);
        check("wrap", press_count, 16'h0000);
        repeat (20) tick(1'b0, 1'b0);
        for (int i = 1; i <= 12; i++) tick(1'b1, i == 10);
        check("clr_with_press", press_count, 16'd1);
        tick(1'b1, 1'b1);
        check("clr_alone", press_count, 16'd0);
        repeat (20) tick(1'b0, 1'b0);

        // random bounce segments with occasional clears
        for (int seg = 0; seg < 60; seg++) begin
            logic b;
            int len;
            b = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 14));
            for (int k = 0; k < len; k++) tick(b, $urandom_range(0, 15) == 0);
        end
        repeat (60) tick(1'b1, 1'b0);
        repeat (20) tick(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
